tag_rx_ctrl: RTL
================

# tag_rx_ctrl

Receive-window controller for the FM0 clock-recovery/decoder block (pulse_cnt) in the reader datapath. It arms the decoder after each reader command and enforces a no-reply timeout and a frame watchdog. It captures the decoded bit vector on completion, checks the bit count against the expected reply length, and presents the result upstream with a valid/ready handshake. It holds the decoder in reset whenever no reply is expected, so stray edges are never decoded.

## Interface
- T1_MAX, 16'd400: LISTEN cycles allowed before the first decoded bit; expiry gives status 01.
- FRAME_MAX, 16'd20000: LISTEN cycles allowed in total; expiry gives status 11.
- clk  in  1  system clock, same as decoder (6.4 MHz).
- reset  in  1  reset, asynchronous and active-low; all state returns to IDLE.
- start  in  1  one-cycle pulse from command FSM at end of reader transmission; honoured only in IDLE.
- abort  in  1  level; returns to IDLE from any state, no result issued.
- exp_len  in  16  expected reply bit count; sampled on accepted start.
- cdr_rst_n  out  1  registered; drives decoder's active-low sync reset.
- cdr_finish  in  1  decoder end-of-reply pulse (Tag_finish).
- cdr_number  in  16  decoder bit counter (Tag_data_number).
- cdr_data  in  256  decoder shift register (Tag_data); newest bit at bit 0.
- rx_valid  out  1  result available.
- rx_ready  in  1  upstream accepts result.
- rx_data  out  256  captured cdr_data.
- rx_len  out  16  captured cdr_number.
- rx_status  out  2  00 ok, 01 no reply, 10 length error, 11 frame overrun.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ARM, LISTEN, CHECK, DONE. All outputs are registered.
- IDLE:
  - cdr_rst_n=0, rx_valid=0.
  - start=1 latches exp_len into len_q.
  - If len_q would be 0 or >256, go to DONE with status 10, rx_len=0, rx_data=0. The decoder is never armed.
  - Otherwise go to ARM.
- ARM:
  - One cycle, cdr_rst_n kept 0 so the decoder sees at least one synchronous reset cycle.
  - Clear timer, clear seen. Go to LISTEN.
- LISTEN:
  - cdr_rst_n=1. 16-bit timer increments each cycle and saturates at 16'hFFFF.
  - seen is set when cdr_number!=0 and stays set.
  - Priority, highest first:
    - abort: go to IDLE.
    - cdr_finish: capture cdr_data/cdr_number, go to CHECK.
    - timer==FRAME_MAX-1: go to DONE, status 11.
    - !seen && cdr_number==0 && timer==T1_MAX-1: go to DONE, status 01.
  - Timeout and overrun results carry rx_data=0 and rx_len=cdr_number at that cycle.
- CHECK:
  - One cycle. Status is 00 if captured number == len_q, else 10.
  - A finish with number 0 gives status 10. A number >256 always gives 10.
  - Go to DONE.
- DONE:
  - cdr_rst_n=0, rx_valid=1. rx_data/rx_len/rx_status are stable until the handshake.
  - rx_valid && rx_ready: go to IDLE next cycle, rx_valid drops.
  - abort: go to IDLE, rx_valid drops, no transfer.
- start outside IDLE is ignored and never queued. A start arriving in the same cycle as the DONE→IDLE handshake is ignored.
- rx_data/rx_len/rx_status keep their last values in IDLE. They only update on entry to DONE.

## Timing
- Reset values: cdr_rst_n=0, rx_valid=0, rx_data=0, rx_len=0, rx_status=00, busy=0. State is IDLE and the timer is 0.
- start sampled at cycle n:
  - busy=1 and ARM at n+1.
  - cdr_rst_n=1 from n+2, which is the first LISTEN cycle.
  - Invalid exp_len: rx_valid=1 at n+1.
- cdr_finish sampled at cycle k: CHECK at k+1, rx_valid=1 at k+2.
- No reply: LISTEN lasts exactly T1_MAX cycles; rx_valid=1 at n+2+T1_MAX. cdr_rst_n returns to 0 in the same cycle.
- Frame overrun: rx_valid at n+2+FRAME_MAX.
- Simultaneous events:
  - finish and timeout in the same cycle: finish wins.
  - abort with anything: abort wins.
  - rx_ready while rx_valid=0 has no effect.
- Asynchronous reset mid-frame: outputs return to reset values immediately, including cdr_rst_n=0, so the decoder is held in reset.

## Test plan
- exp_len=16, decoder model emits 16 bits then finish → rx_valid 2 cycles after finish, status 00, rx_len=16, rx_data[15:0] equals sent pattern; rx_ready=1 gives IDLE, busy=0.
- start with decoder silent, T1_MAX=400 → rx_valid exactly 402 cycles after start, status 01, rx_len=0, cdr_rst_n low from that cycle.
- exp_len=32, decoder finishes at 20 bits → status 10, rx_len=20; a second finish with number 0 → status 10, rx_len=0.
- exp_len=0, then exp_len=300 → each gives rx_valid at n+1 with status 10 and cdr_rst_n never high.
- cdr_number ramps without finish, FRAME_MAX=1000 → status 11 at n+1002. rx_ready held low 50 cycles → outputs stable, start pulses ignored.
- abort in LISTEN and in DONE → IDLE next cycle, no rx_valid. Async reset mid-LISTEN → all outputs at reset values without a clock edge.

Source files
------------

// File: rtl/tag_rx_ctrl_if.sv
// rtl/tag_rx_ctrl_if.sv - result handshake bundle between tag_rx_ctrl and its upstream consumer
interface tag_rx_ctrl_if;
    logic         rx_valid;
    logic         rx_ready;
    logic [255:0] rx_data;
    logic [15:0]  rx_len;
    logic [1:0]   rx_status;

    modport master (
        output rx_valid,
        output rx_data,
        output rx_len,
        output rx_status,
        input  rx_ready
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        input  rx_len,
        input  rx_status,
        output rx_ready
    );
endinterface

// File: rtl/tag_rx_ctrl.sv
// rtl/tag_rx_ctrl.sv - receive-window controller arming the FM0 decoder and reporting the reply
module tag_rx_ctrl #(
    parameter logic [15:0] T1_MAX    = 16'd400,
    parameter logic [15:0] FRAME_MAX = 16'd20000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [15:0]   exp_len,
    output logic          cdr_rst_n,
    input  logic          cdr_finish,
    input  logic [15:0]   cdr_number,
    input  logic [255:0]  cdr_data,
    output logic          busy,
    tag_rx_ctrl_if.master rx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_LISTEN,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [15:0] T1_LAST    = T1_MAX - 16'd1;
    localparam logic [15:0] FRAME_LAST = FRAME_MAX - 16'd1;

    state_t       state;
    logic [15:0]  timer;
    logic [15:0]  len_q;
    logic [15:0]  cap_len;
    logic [255:0] cap_data;
    logic         seen;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            timer        <= 16'd0;
            len_q        <= 16'd0;
            cap_len      <= 16'd0;
            cap_data     <= '0;
            seen         <= 1'b0;
            cdr_rst_n    <= 1'b0;
            busy         <= 1'b0;
            rx.rx_valid  <= 1'b0;
            rx.rx_data   <= '0;
            rx.rx_len    <= 16'd0;
            rx.rx_status <= 2'b00;
        end else if (abort) begin
            // Result registers are left alone: an aborted frame issues nothing.
            state       <= S_IDLE;
            cdr_rst_n   <= 1'b0;
            busy        <= 1'b0;
            rx.rx_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_q <= exp_len;
                        busy  <= 1'b1;
                        if (exp_len == 16'd0 || exp_len > 16'd256) begin
                            state        <= S_DONE;
                            rx.rx_valid  <= 1'b1;
                            rx.rx_status <= 2'b10;
                            rx.rx_len    <= 16'd0;
                            rx.rx_data   <= '0;
                        end else begin
                            state <= S_ARM;
                        end
                    end
                end

                S_ARM: begin
                    timer     <= 16'd0;
                    seen      <= 1'b0;
                    cdr_rst_n <= 1'b1;
                    state     <= S_LISTEN;
                end

                S_LISTEN: begin
                    if (timer != 16'hFFFF) begin
                        timer <= timer + 16'd1;
                    end
                    if (cdr_number != 16'd0) begin
                        seen <= 1'b1;
                    end
                    // A finish on the timeout cycle still counts as a reply.
                    if (cdr_finish) begin
                        cap_data <= cdr_data;
                        cap_len  <= cdr_number;
                        state    <= S_CHECK;
                    end else if (timer == FRAME_LAST) begin
                        state        <= S_DONE;
                        cdr_rst_n    <= 1'b0;
                        rx.rx_valid  <= 1'b1;
                        rx.rx_status <= 2'b11;
                        rx.rx_len    <= cdr_number;
                        rx.rx_data   <= '0;
                    end else if (!seen && cdr_number == 16'd0 && timer == T1_LAST) begin
                        state        <= S_DONE;
                        cdr_rst_n    <= 1'b0;
                        rx.rx_valid  <= 1'b1;
                        rx.rx_status <= 2'b01;
                        rx.rx_len    <= cdr_number;
                        rx.rx_data   <= '0;
                    end
                end

                S_CHECK: begin
                    // len_q is always 1..256 here, so zero or oversize counts can never match.
                    state        <= S_DONE;
                    cdr_rst_n    <= 1'b0;
                    rx.rx_valid  <= 1'b1;
                    rx.rx_status <= (cap_len == len_q) ? 2'b00 : 2'b10;
                    rx.rx_len    <= cap_len;
                    rx.rx_data   <= cap_data;
                end

                S_DONE: begin
                    if (rx.rx_ready) begin
                        state       <= S_IDLE;
                        busy        <= 1'b0;
                        rx.rx_valid <= 1'b0;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    cdr_rst_n <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
